// File: rtl/lpif_txrx_flit_tx_credit.sv
// rtl/lpif_txrx_flit_tx_credit.sv - credit-managed buffered flit transmit engine striping flits across PHY channels.
// Optional feature macro: LPIF_TX_PARITY_EN (per-channel even parity in bit CH_WIDTH-2).
module lpif_txrx_flit_tx_credit #(
  parameter int NUM_CH     = 8,
  parameter int CH_WIDTH   = 80,
  parameter int PAYLOAD_W  = 537,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDIT_W   = 8
) (
  input  logic                         clk_wr,
  input  logic                         rst_wr,
  input  logic                         tx_online,
  input  logic [CREDIT_W-1:0]          init_credit,
  input  logic                         credit_return,
  input  logic [7:0]                   stb_period,
  input  logic [PAYLOAD_W-1:0]         dstrm_payload,
  input  logic                         dstrm_valid,
  output logic                         dstrm_ready,
  output logic [NUM_CH*CH_WIDTH-1:0]   tx_phy,
  output logic [31:0]                  debug_status
);
  localparam int SLICE_W = CH_WIDTH - 4;
  localparam int PAD_W   = NUM_CH * SLICE_W;
  localparam int AW      = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] ST_OFFLINE = 2'd0;
  localparam logic [1:0] ST_INIT    = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  if (PAYLOAD_W > NUM_CH * (CH_WIDTH - 4)) begin : g_chk_payload
    $error("PAYLOAD_W does not fit in NUM_CH*(CH_WIDTH-4)");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (CREDIT_W > 16) begin : g_chk_credit
    $error("CREDIT_W must be at most 16");
  end

  logic [1:0]           state;
  logic [PAYLOAD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic [CREDIT_W-1:0]  credit;
  logic [7:0]           stb_cnt, stb_lim, stb_eff;
  logic                 sticky_ovf, sticky_wait;

  logic run, full, empty, push, pop, strobe;
  logic [PAD_W-1:0]              pad;
  logic [NUM_CH*CH_WIDTH-1:0]    phy_next;

  assign run         = (state == ST_RUN);
  assign full        = (count == (AW+1)'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign dstrm_ready = run & ~full;
  assign push        = dstrm_valid & dstrm_ready;
  assign pop         = run & tx_online & ~empty & (credit != '0);
  // The period is resampled only at the start of each strobe window.
  assign stb_eff     = (stb_cnt == 8'd0) ? stb_period : stb_lim;
  assign strobe      = run & (stb_cnt == 8'd0) & (stb_period != 8'd0);

  always_comb begin
    pad = '0;
    pad[PAYLOAD_W-1:0] = pop ? mem[rd_ptr] : '0;
    phy_next = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      phy_next[c*CH_WIDTH]              = pop;
      phy_next[c*CH_WIDTH+1]            = strobe;
      phy_next[c*CH_WIDTH+2 +: SLICE_W] = pad[c*SLICE_W +: SLICE_W];
`ifdef LPIF_TX_PARITY_EN
      phy_next[c*CH_WIDTH+CH_WIDTH-2]   = ^phy_next[c*CH_WIDTH +: CH_WIDTH-2];
`else
      phy_next[c*CH_WIDTH+CH_WIDTH-2]   = 1'b0;
`endif
      phy_next[c*CH_WIDTH+CH_WIDTH-1]   = 1'b1;
    end
    if (!(run && tx_online)) phy_next = '0;
  end

  always_ff @(posedge clk_wr) begin
    if (push) mem[wr_ptr] <= dstrm_payload;
  end

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      state        <= ST_OFFLINE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      credit       <= '0;
      stb_cnt      <= 8'd0;
      stb_lim      <= 8'd0;
      sticky_ovf   <= 1'b0;
      sticky_wait  <= 1'b0;
      tx_phy       <= '0;
      debug_status <= 32'd0;
    end else begin
      tx_phy       <= phy_next;
      debug_status <= {4'd0, state, sticky_wait, sticky_ovf, 8'(count), 16'(credit)};
      if (run && !empty && credit == '0) sticky_wait <= 1'b1;
      if (!tx_online) begin
        state   <= ST_OFFLINE;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        credit  <= '0;
        stb_cnt <= 8'd0;
      end else begin
        case (state)
          ST_OFFLINE: state <= ST_INIT;
          ST_INIT: begin
            state  <= ST_RUN;
            credit <= init_credit;
          end
          ST_RUN: begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (pop && !credit_return) begin
              credit <= credit - CREDIT_W'(1);
            end else if (!pop && credit_return) begin
              if (credit == '1) sticky_ovf <= 1'b1;
              else              credit <= credit + CREDIT_W'(1);
            end
            if (stb_cnt == 8'd0) stb_lim <= stb_period;
            if (stb_eff == 8'd0 || stb_cnt == stb_eff - 8'd1) stb_cnt <= 8'd0;
            else                                              stb_cnt <= stb_cnt + 8'd1;
          end
          default: state <= ST_OFFLINE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lpif_txrx_flit_tx_credit.sv
// tb/tb_lpif_txrx_flit_tx_credit.sv - randomized self-checking bench with queue-based reference model.
module tb_lpif_txrx_flit_tx_credit;
  localparam int NCH   = 8;
  localparam int CW    = 80;
  localparam int PW    = 537;
  localparam int SL    = CW - 4;
  localparam int TW    = NCH * CW;
  localparam int DEPTH = 4;
  localparam int CMAX  = 255;

  logic           clk_wr = 1'b0;
  logic           rst_wr, tx_online, credit_return, dstrm_valid;
  logic [7:0]     init_credit, stb_period;
  logic [PW-1:0]  dstrm_payload;
  logic           dstrm_ready;
  logic [TW-1:0]  tx_phy;
  logic [31:0]    debug_status;

  int checks = 0;
  int failures = 0;

  int             m_state, m_credit, m_cnt, m_lim;
  bit             m_ovf, m_wait;
  logic [PW-1:0]  m_q [$];
  logic [TW-1:0]  exp_phy;
  logic [31:0]    exp_dbg;

  always #5 clk_wr = ~clk_wr;

  lpif_txrx_flit_tx_credit #(
    .NUM_CH(NCH), .CH_WIDTH(CW), .PAYLOAD_W(PW), .FIFO_DEPTH(DEPTH), .CREDIT_W(8)
  ) dut (
    .clk_wr(clk_wr), .rst_wr(rst_wr), .tx_online(tx_online), .init_credit(init_credit),
    .credit_return(credit_return), .stb_period(stb_period), .dstrm_payload(dstrm_payload),
    .dstrm_valid(dstrm_valid), .dstrm_ready(dstrm_ready), .tx_phy(tx_phy),
    .debug_status(debug_status)
  );

  task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] build(input logic [PW-1:0] pl, input bit psh, input bit stb);
    logic [TW-1:0] w;
    w = '0;
    for (int c = 0; c < NCH; c++) begin
      w[c*CW]      = psh;
      w[c*CW+1]    = stb;
      w[c*CW+CW-1] = 1'b1;
    end
    for (int k = 0; k < PW; k++) w[(k / SL) * CW + 2 + (k % SL)] = pl[k];
`ifdef LPIF_TX_PARITY_EN
    for (int c = 0; c < NCH; c++) w[c*CW+CW-2] = ^w[c*CW +: CW-2];
`endif
    return w;
  endfunction

  task automatic model_step();
    bit rdy, acc, pp, stb;
    int p;
    logic [PW-1:0] head;
    rdy  = (m_state == 2) && (m_q.size() < DEPTH);
    acc  = dstrm_valid && rdy;
    pp   = (m_state == 2) && tx_online && (m_q.size() > 0) && (m_credit > 0);
    stb  = (m_state == 2) && (m_cnt == 0) && (stb_period != 0);
    head = pp ? m_q[0] : '0;
    if (rst_wr) begin
      m_state = 0; m_q.delete(); m_credit = 0; m_cnt = 0; m_lim = 0;
      m_ovf = 0; m_wait = 0; exp_phy = '0; exp_dbg = '0;
    end else begin
      exp_dbg = {4'd0, 2'(m_state), m_wait, m_ovf, 8'(m_q.size()), 16'(m_credit)};
      exp_phy = (m_state == 2 && tx_online) ? build(head, pp, stb) : '0;
      if (m_state == 2 && m_q.size() > 0 && m_credit == 0) m_wait = 1;
      if (!tx_online) begin
        m_state = 0; m_q.delete(); m_credit = 0; m_cnt = 0;
      end else if (m_state == 0) begin
        m_state = 1;
      end else if (m_state == 1) begin
        m_state = 2; m_credit = init_credit;
      end else begin
        if (pp)  void'(m_q.pop_front());
        if (acc) m_q.push_back(dstrm_payload);
        m_credit = m_credit - int'(pp) + int'(credit_return);
        if (m_credit > CMAX) begin m_credit = CMAX; m_ovf = 1; end
        p = (m_cnt == 0) ? int'(stb_period) : m_lim;
        if (m_cnt == 0) m_lim = stb_period;
        m_cnt = (p == 0) ? 0 : (m_cnt + 1) % p;
      end
    end
  endtask

  task automatic tick();
    bit exp_rdy;
    model_step();
    @(negedge clk_wr);
    exp_rdy = (m_state == 2) && (m_q.size() < DEPTH);
    check("ready", TW'(dstrm_ready), TW'(exp_rdy));
    check("tx_phy", tx_phy, exp_phy);
    check("debug", TW'(debug_status), TW'(exp_dbg));
  endtask

  task automatic rand_payload();
    logic [543:0] r;
    for (int i = 0; i < 17; i++) r[i*32 +: 32] = $urandom;
    if ($urandom_range(0, 3) == 0) r = 544'd1;
    dstrm_payload = r[PW-1:0];
  endtask

  task automatic phase(input int n, input int vpct, input int rpct, input int per);
    for (int i = 0; i < n; i++) begin
      dstrm_valid   = ($urandom_range(0, 99) < vpct);
      credit_return = ($urandom_range(0, 99) < rpct);
      stb_period    = 8'(per);
      rand_payload();
      tick();
    end
  endtask

  initial begin
    rst_wr = 1'b1; tx_online = 1'b0; init_credit = 8'd3; credit_return = 1'b0;
    stb_period = 8'd4; dstrm_valid = 1'b0; dstrm_payload = '0;
    m_state = 0; m_credit = 0; m_cnt = 0; m_lim = 0; m_ovf = 0; m_wait = 0;
    exp_phy = '0; exp_dbg = '0;
    @(negedge clk_wr);
    phase(3, 50, 50, 4);
    check("reset_phy", tx_phy, '0);
    rst_wr = 1'b0;
    phase(3, 50, 50, 4);
    // Link-up: OFFLINE -> INIT -> RUN, credit 3 visible with marker set.
    tx_online = 1'b1;
    phase(3, 0, 0, 4);
    check("linkup_credit", TW'(debug_status[15:0]), TW'(16'd3));
    check("linkup_state", TW'(debug_status[27:26]), TW'(2'd2));
    check("linkup_marker", TW'({tx_phy[CW-1], tx_phy[TW-1]}), TW'(2'b11));
    phase(8, 100, 0, 4);
    check("wait_sticky", TW'(debug_status[25]), TW'(1'b1));
    phase(12, 0, 30, 4);
    phase(10, 100, 0, 4);
    phase(20, 50, 25, 4);
    phase(20, 50, 30, 0);
    phase(20, 60, 40, 3);
    tx_online = 1'b0;
    phase(3, 50, 50, 4);
    init_credit = 8'd255;
    tx_online = 1'b1;
    phase(30, 60, 80, 5);
    check("ovf_sticky", TW'(debug_status[24]), TW'(1'b1));
    phase(10, 100, 0, 2);
    tx_online = 1'b0;
    phase(2, 50, 50, 2);
    tx_online = 1'b1;
    init_credit = 8'd2;
    phase(15, 80, 20, 1);
    rst_wr = 1'b1;
    phase(1, 50, 50, 4);
    rst_wr = 1'b0;
    for (int blk = 0; blk < 60; blk++) begin
      tx_online   = ($urandom_range(0, 9) != 0);
      init_credit = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
      rst_wr      = ($urandom_range(0, 29) == 0);
      phase(1, 50, 50, 4);
      rst_wr      = 1'b0;
      phase(int'($urandom_range(5, 20)), int'($urandom_range(0, 100)),
            int'($urandom_range(0, 100)), int'($urandom_range(0, 6)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
